exec_sequencer: RTL
===================

Name: exec_sequencer

Overview:
- Parametrised successor to the fixed 5-phase counter and exec-gated clock enable of the multi-cycle SIMPLE core.
- Generates a one-hot phase vector of configurable length with a per-phase clock enable.
- Adds run/stop/single-step control, a memory-wait stall, a sticky halt, a PC breakpoint, and saturating instruction and stall counters.
- Sits between the debounced exec/step buttons and the core datapath registers (IR/AR/BR/DR/MDR/PC enables); the counters feed the 7-seg display mux.

Parameters:
NPHASE, 5, phases per instruction (>=2); phase 0 = fetch, phase NPHASE-1 = PC update/retire
PC_W, 16, PC and breakpoint width
CNT_W, 32, instruction and stall counter width
WAIT_PHASE, 1, phase index in which mem_ready is sampled (< NPHASE)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  reset; asynchronous, active-low
exec  in  1  debounced run/stop button level; the block detects rising edges internally
step  in  1  debounced single-step button level; the block detects rising edges internally
halt  in  1  decoded HLT, valid during phase NPHASE-1
mem_ready  in  1  memory ready; sampled only in WAIT_PHASE
bp_en  in  1  breakpoint enable
bp_addr  in  PC_W  breakpoint address
pc  in  PC_W  current PC from the PC block
phase  out  NPHASE  one-hot current phase
phase_idx  out  $clog2(NPHASE)  binary current phase
ce  out  1  phase advances at the end of this cycle
running  out  1  state is RUN or STEP
halted  out  1  state is HALTED
bp_hit  out  1  stopped on a breakpoint
instr_cnt  out  CNT_W  retired instructions
stall_cnt  out  CNT_W  stalled cycles

Behaviour:
- States: IDLE, RUN, STEP, HALTED.
- Reset (async, rst_n=0) values:
  - state=IDLE, phase_idx=0, phase=1
  - ce=0, bp_hit=0, counters=0
  - exec_q=0, step_q=0, stop_pend=0, bp_skip=0
  - Reset mid-instruction abandons that instruction; no partial retire is counted.
- Edge detection: exec_q/step_q are registered copies of the inputs. ex_rise = exec & ~exec_q; st_rise = step & ~step_q.
- Stall: stall = (phase_idx==WAIT_PHASE) & ~mem_ready.
- Breakpoint block: bp_blk = (state==RUN) & (phase_idx==0) & bp_en & (pc==bp_addr) & ~bp_skip.
- Clock enable: ce = running & ~stall & ~bp_blk, combinational.
- Phase advance: when ce=1, phase_idx advances by 1 and wraps from NPHASE-1 to 0. Otherwise phase_idx holds. phase = 1<<phase_idx.
- Retire: ce=1 with phase_idx==NPHASE-1. Each retire increments instr_cnt.
- stall_cnt increments each cycle with running & stall.
- Both counters saturate at all-ones.
- IDLE:
  - ex_rise -> RUN, with bp_skip=1 and bp_hit=0.
  - st_rise -> STEP, with bp_hit=0.
  - If ex_rise and st_rise occur in the same cycle, ex_rise wins.
  - First ce=1 occurs in the cycle after the transition.
- RUN:
  - ex_rise sets stop_pend.
  - bp_blk=1 -> IDLE, bp_hit=1, phase held at 0.
  - bp_skip clears on the first ce in phase 0.
  - At retire:
    - halt=1 -> HALTED (halt has priority over stop_pend).
    - Else stop_pend=1 -> IDLE, and stop_pend clears.
    - Else stay in RUN.
- STEP:
  - Executes exactly one instruction from the current phase through retire, then goes to IDLE, or to HALTED if halt=1.
  - Breakpoint is ignored; ex_rise and st_rise are ignored.
- HALTED:
  - Sticky; only reset leaves it.
  - ce=0; exec and step are ignored; phase_idx stays at 0 after the final retire.
- Stop requests (ex_rise in RUN) and stall never split an instruction; a stop takes effect only at an instruction boundary.

Test Plan:
- Reset, exec pulse, mem_ready=1, halt=0, bp_en=0, 20 cycles -> phase cycles 1,2,4,8,16 with ce=1 every cycle; instr_cnt=4 after 20 ce cycles; stall_cnt=0.
- In RUN, hold mem_ready=0 for 3 cycles in phase 1 -> phase_idx stays 1 for 4 cycles with ce=0 during the stall; stall_cnt=3; instr_cnt is unchanged until the retire.
- From IDLE, step pulse -> exactly 5 ce cycles, instr_cnt +1, return to IDLE at phase 0; a second step pulse during STEP has no effect.
- bp_en=1, bp_addr=0x0003, PC increments per instruction, exec pulse -> stop in IDLE at phase 0 with pc=3 and bp_hit=1; a new exec pulse resumes and retires PC 3 without re-triggering.
- halt=1 asserted in phase 4 of the 2nd instruction -> halted=1, instr_cnt=2, ce stays 0; exec and step pulses are ignored; rst_n=0 returns to IDLE with counters 0.
- exec pulse during RUN in phase 2 -> the current instruction completes (phases 3,4) and then the block enters IDLE; exec and step rising in the same IDLE cycle -> RUN.

Source files
------------

// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if: control, breakpoint and status bundle between the sequencer and its surroundings.
interface exec_sequencer_if #(
   parameter int NPHASE = 5,
   parameter int PC_W   = 16,
   parameter int CNT_W  = 32
);
   localparam int IW = $clog2(NPHASE);
   logic              exec;
   logic              step;
   logic              halt;
   logic              mem_ready;
   logic              bp_en;
   logic [PC_W-1:0]   bp_addr;
   logic [PC_W-1:0]   pc;
   logic [NPHASE-1:0] phase;
   logic [IW-1:0]     phase_idx;
   logic              ce;
   logic              running;
   logic              halted;
   logic              bp_hit;
   logic [CNT_W-1:0]  instr_cnt;
   logic [CNT_W-1:0]  stall_cnt;
   modport slave (
      input  exec, step, halt, mem_ready, bp_en, bp_addr, pc,
      output phase, phase_idx, ce, running, halted, bp_hit, instr_cnt, stall_cnt
   );
   modport master (
      output exec, step, halt, mem_ready, bp_en, bp_addr, pc,
      input  phase, phase_idx, ce, running, halted, bp_hit, instr_cnt, stall_cnt
   );
endinterface

// File: rtl/exec_sequencer.sv
// exec_sequencer: one-hot phase sequencer with run/stop/step control, memory stall,
// sticky halt, PC breakpoint and saturating instruction/stall counters.
module exec_sequencer #(
   parameter int NPHASE     = 5,
   parameter int PC_W       = 16,
   parameter int CNT_W      = 32,
   parameter int WAIT_PHASE = 1
) (
   input  logic clk,
   input  logic rst_n,
   exec_sequencer_if.slave bus
);
   localparam int IW = $clog2(NPHASE);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_HALTED} state_t;
   state_t           r_state, w_state_nx;
   logic [IW-1:0]    r_phase_idx;
   logic             r_exec_q, r_step_q, r_stop_pend, r_bp_skip, r_bp_hit;
   logic             w_stop_nx, w_skip_nx, w_hit_nx;
   logic [CNT_W-1:0] r_instr_cnt, r_stall_cnt;
   logic             w_ex_rise, w_st_rise, w_stall, w_bp_blk, w_running, w_ce, w_retire, w_last;

   assign w_ex_rise = bus.exec & ~r_exec_q;
   assign w_st_rise = bus.step & ~r_step_q;
   assign w_last    = r_phase_idx == IW'(NPHASE - 1);
   assign w_stall   = (r_phase_idx == IW'(WAIT_PHASE)) & ~bus.mem_ready;
   assign w_bp_blk  = (r_state == S_RUN) & (r_phase_idx == '0) & bus.bp_en & (bus.pc == bus.bp_addr) & ~r_bp_skip;
   assign w_running = (r_state == S_RUN) | (r_state == S_STEP);
   assign w_ce      = w_running & ~w_stall & ~w_bp_blk;
   assign w_retire  = w_ce & w_last;

   assign bus.phase     = NPHASE'(1) << r_phase_idx;
   assign bus.phase_idx = r_phase_idx;
   assign bus.ce        = w_ce;
   assign bus.running   = w_running;
   assign bus.halted    = r_state == S_HALTED;
   assign bus.bp_hit    = r_bp_hit;
   assign bus.instr_cnt = r_instr_cnt;
   assign bus.stall_cnt = r_stall_cnt;

   always_comb begin
      w_state_nx = r_state;
      w_stop_nx  = r_stop_pend;
      w_skip_nx  = r_bp_skip;
      w_hit_nx   = r_bp_hit;
      case (r_state)
         S_IDLE:
            if (w_ex_rise) begin
               w_state_nx = S_RUN;
               w_skip_nx  = 1'b1;
               w_hit_nx   = 1'b0;
            end else if (w_st_rise) begin
               w_state_nx = S_STEP;
               w_hit_nx   = 1'b0;
            end
         S_RUN: begin
            if (w_ex_rise) w_stop_nx = 1'b1;
            if (w_ce && r_phase_idx == '0) w_skip_nx = 1'b0;
            if (w_bp_blk) begin
               w_state_nx = S_IDLE;
               w_hit_nx   = 1'b1;
               w_stop_nx  = 1'b0;
            end else if (w_retire) begin
               // halt outranks a pending stop; a stop only lands on an instruction boundary
               if (bus.halt) w_state_nx = S_HALTED;
               else if (r_stop_pend) begin
                  w_state_nx = S_IDLE;
                  w_stop_nx  = 1'b0;
               end
            end
         end
         S_STEP:
            if (w_retire) w_state_nx = bus.halt ? S_HALTED : S_IDLE;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_phase_idx <= '0;
         r_exec_q    <= 1'b0;
         r_step_q    <= 1'b0;
         r_stop_pend <= 1'b0;
         r_bp_skip   <= 1'b0;
         r_bp_hit    <= 1'b0;
         r_instr_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_exec_q    <= bus.exec;
         r_step_q    <= bus.step;
         r_stop_pend <= w_stop_nx;
         r_bp_skip   <= w_skip_nx;
         r_bp_hit    <= w_hit_nx;
         if (w_ce) r_phase_idx <= w_last ? '0 : r_phase_idx + IW'(1);
         if (w_retire && !(&r_instr_cnt)) r_instr_cnt <= r_instr_cnt + CNT_W'(1);
         if (w_running && w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end
endmodule
